// File: rtl/zed_pipe_pkg.sv
// Shared Zed pipeline types and constants for the mask drain.
// ZED_DRAIN_BITPACK_EN selects 1-bit pixels packed 32 per word instead of 4 bytes per word.
package zed_pipe_pkg;

    localparam int IMG_SIZE_DEF = 900;
    localparam int LANES_BYTE   = 4;
    localparam int LANES_BIT    = 32;

`ifdef ZED_DRAIN_BITPACK_EN
    localparam int LANES = LANES_BIT;
`else
    localparam int LANES = LANES_BYTE;
`endif

    // Lane counters must hold LANES itself, so one bit wider than the lane index.
    localparam int LIDX_W = $clog2(LANES);
    localparam int LANE_W = LIDX_W + 1;

    typedef enum logic [1:0] {
        FILL = 2'd0,
        SEND = 2'd1,
        EOF  = 2'd2
    } drain_state_t;

endpackage

// File: rtl/zed_lane_packer.sv
// Lane register file for the mask drain: collects pixels into one 32-bit word plus keep mask.
// ZED_DRAIN_BITPACK_EN reduces each pixel to (pix != 0) and stores it as a single bit.
module zed_lane_packer
    import zed_pipe_pkg::*;
(
    input  logic              clk,
    input  logic              i_wr_en,
    input  logic [LIDX_W-1:0] i_lane,
    input  logic [7:0]        i_pix,
    input  logic              i_clr,
    output logic [31:0]       o_word,
    output logic [3:0]        o_keep
);

`ifdef ZED_DRAIN_BITPACK_EN
    logic [31:0] r_bits;
    logic [31:0] r_valid;

    always_ff @(posedge clk) begin
        if (i_clr) begin
            r_bits  <= '0;
            r_valid <= '0;
        end else if (i_wr_en) begin
            r_bits[i_lane]  <= |i_pix;
            r_valid[i_lane] <= 1'b1;
        end
    end

    // A byte lane is kept as soon as any of its bits carries a pixel.
    always_comb begin
        o_word = r_bits;
        o_keep = '0;
        for (int k = 0; k < 4; k++) begin
            o_keep[k] = |r_valid[8*k +: 8];
        end
    end
`else
    logic [3:0][7:0] r_lanes;
    logic [3:0]      r_valid;

    always_ff @(posedge clk) begin
        if (i_clr) begin
            r_lanes <= '0;
            r_valid <= '0;
        end else if (i_wr_en) begin
            r_lanes[i_lane] <= i_pix;
            r_valid[i_lane] <= 1'b1;
        end
    end

    always_comb begin
        o_word = r_lanes;
        o_keep = r_valid;
    end
`endif

endmodule

// File: rtl/zed_mask_drain.sv
// Zed mask drain: reads mask pixels from the destination FIFO and streams packed, framed words.
// ZED_DRAIN_BITPACK_EN switches to 1-bit pixels packed 32 per word.
//
// state | meaning
// FILL  | issue FIFO reads and collect returned pixels until the word holds target pixels
// SEND  | present the word on the stream; hold it until accepted
// EOF   | one cycle after the tlast handshake; pulse frame_done, restart pixel count
module zed_mask_drain
    import zed_pipe_pkg::*;
#(
    parameter int IMG_SIZE    = IMG_SIZE_DEF,
    parameter int FRAME_CNT_W = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    output logic                   dst_fifo_rd_en,
    input  logic [7:0]             dst_fifo_dout,
    input  logic                   dst_fifo_empty,
    output logic [31:0]            m_tdata,
    output logic [3:0]             m_tkeep,
    output logic                   m_tvalid,
    input  logic                   m_tready,
    output logic                   m_tlast,
    output logic                   frame_done,
    output logic [FRAME_CNT_W-1:0] frame_cnt
);

    localparam int PIX_W = $clog2(IMG_SIZE + 1);

    drain_state_t           r_state;
    drain_state_t           w_next;
    logic [PIX_W-1:0]       r_pix_cnt;
    logic [LANE_W-1:0]      r_issued;
    logic [LANE_W-1:0]      r_received;
    logic                   r_rd_pend;
    logic [FRAME_CNT_W-1:0] r_frame_cnt;
    logic [LANE_W-1:0]      w_target;
    logic                   w_last;
    logic                   w_hs;
    int                     w_remain;

    // Word size is LANES except for the tail of the frame.
    always_comb begin
        w_remain = IMG_SIZE - int'(r_pix_cnt);
        w_target = (w_remain < LANES) ? LANE_W'(w_remain) : LANE_W'(LANES);
        w_last   = (w_remain <= LANES);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= FILL;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            FILL: if (r_rd_pend && (r_received + LANE_W'(1) == w_target)) w_next = SEND;
            SEND: if (m_tready) w_next = w_last ? EOF : FILL;
            EOF:  w_next = FILL;
            default: w_next = FILL;
        endcase
    end

    // Reads are suppressed while rst is high so no FIFO entry is consumed and then discarded.
    always_comb begin
        dst_fifo_rd_en = (r_state == FILL) && (r_issued < w_target) && !dst_fifo_empty && !rst;
        m_tvalid       = (r_state == SEND);
        m_tlast        = (r_state == SEND) && w_last;
        frame_done     = (r_state == EOF);
    end

    assign w_hs      = m_tvalid && m_tready;
    assign frame_cnt = r_frame_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_issued    <= '0;
            r_received  <= '0;
            r_pix_cnt   <= '0;
            r_rd_pend   <= 1'b0;
            r_frame_cnt <= '0;
        end else begin
            r_rd_pend <= dst_fifo_rd_en;
            if (dst_fifo_rd_en) r_issued <= r_issued + LANE_W'(1);
            if (r_rd_pend) r_received <= r_received + LANE_W'(1);
            if (w_hs) begin
                r_issued   <= '0;
                r_received <= '0;
                r_pix_cnt  <= r_pix_cnt + PIX_W'(w_target);
                if (w_last) r_frame_cnt <= r_frame_cnt + FRAME_CNT_W'(1);
            end
            if (r_state == EOF) r_pix_cnt <= '0;
        end
    end

    zed_lane_packer u_packer (
        .clk     (clk),
        .i_wr_en (r_rd_pend && !rst),
        .i_lane  (r_received[LIDX_W-1:0]),
        .i_pix   (dst_fifo_dout),
        .i_clr   (rst || w_hs),
        .o_word  (m_tdata),
        .o_keep  (m_tkeep)
    );

endmodule

// File: tb/tb_zed_mask_drain.sv
// Directed bench for zed_mask_drain: a 900-pixel instance and a 10-pixel instance, each with a FIFO model.
// Expectations follow ZED_DRAIN_BITPACK_EN when it is defined.
module tb_zed_mask_drain;

    localparam int NB  = 2;
    localparam int SZ0 = 900;
    localparam int SZ1 = 10;
`ifdef ZED_DRAIN_BITPACK_EN
    localparam int          LN      = 32;
    localparam int          NW0     = 29;
    localparam logic [31:0] FIRST_W = 32'hAAAAAAAA;
    localparam logic [35:0] LAST_WK = {4'h1, 32'h0000000A};
`else
    localparam int          LN      = 4;
    localparam int          NW0     = 225;
    localparam logic [31:0] FIRST_W = 32'h03020100;
    localparam logic [35:0] LAST_WK = {4'hF, 32'h83828180};
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        rd_en [NB];
    logic        empty [NB];
    logic [7:0]  dout [NB];
    logic [31:0] tdata [NB];
    logic [3:0]  tkeep [NB];
    logic        tvalid [NB];
    logic        tready [NB];
    logic        tlast [NB];
    logic        fdone [NB];
    logic [15:0] fcnt [NB];
    logic        force_empty [NB];

    logic [7:0]  mem [NB][4096];
    int          wp [NB] = '{0, 0};
    int          rp [NB] = '{0, 0};
    logic [31:0] cap_data [NB][512];
    logic [3:0]  cap_keep [NB][512];
    logic        cap_last [NB][512];
    int          ncap [NB] = '{0, 0};
    int          nfd [NB] = '{0, 0};
    int          rd_viol [NB] = '{0, 0};

    int n_pass = 0;
    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    zed_mask_drain #(.IMG_SIZE(SZ0), .FRAME_CNT_W(16)) u_big (
        .clk(clk), .rst(rst),
        .dst_fifo_rd_en(rd_en[0]), .dst_fifo_dout(dout[0]), .dst_fifo_empty(empty[0]),
        .m_tdata(tdata[0]), .m_tkeep(tkeep[0]), .m_tvalid(tvalid[0]), .m_tready(tready[0]),
        .m_tlast(tlast[0]), .frame_done(fdone[0]), .frame_cnt(fcnt[0])
    );

    zed_mask_drain #(.IMG_SIZE(SZ1), .FRAME_CNT_W(16)) u_small (
        .clk(clk), .rst(rst),
        .dst_fifo_rd_en(rd_en[1]), .dst_fifo_dout(dout[1]), .dst_fifo_empty(empty[1]),
        .m_tdata(tdata[1]), .m_tkeep(tkeep[1]), .m_tvalid(tvalid[1]), .m_tready(tready[1]),
        .m_tlast(tlast[1]), .frame_done(fdone[1]), .frame_cnt(fcnt[1])
    );

    for (genvar g = 0; g < NB; g++) begin : g_fifo
        assign empty[g] = (wp[g] == rp[g]) || force_empty[g];
    end

    // Standard-mode FIFO model plus stream/frame monitor.
    always @(posedge clk) begin
        for (int k = 0; k < NB; k++) begin
            if (rd_en[k] && !empty[k]) begin
                dout[k] <= mem[k][rp[k]];
                rp[k]   <= rp[k] + 1;
            end
            if (rd_en[k] && empty[k]) rd_viol[k] <= rd_viol[k] + 1;
            if (tvalid[k] && tready[k] && ncap[k] < 512) begin
                cap_data[k][ncap[k]] <= tdata[k];
                cap_keep[k][ncap[k]] <= tkeep[k];
                cap_last[k][ncap[k]] <= tlast[k];
                ncap[k] <= ncap[k] + 1;
            end
            if (fdone[k]) nfd[k] <= nfd[k] + 1;
        end
    end

    function automatic logic [7:0] pix_pat(input int i);
`ifdef ZED_DRAIN_BITPACK_EN
        return (i % 2 == 1) ? 8'hFF : 8'h00;
`else
        return 8'(i % 256);
`endif
    endfunction

    // Expected {keep, word} for npix pixels starting at FIFO entry 'start'.
    function automatic logic [35:0] exp_wk(input int k, input int start, input int npix);
        logic [31:0] w;
        logic [3:0]  kp;
        w  = '0;
        kp = '0;
        for (int j = 0; j < npix; j++) begin
`ifdef ZED_DRAIN_BITPACK_EN
            w[j]    = (mem[k][start + j] != 8'h00);
            kp[j/8] = 1'b1;
`else
            w[8*j +: 8] = mem[k][start + j];
            kp[j]       = 1'b1;
`endif
        end
        return {kp, w};
    endfunction

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_fd(input int k, input int budget, input bit toggle, input string tag);
        int n;
        n = 0;
        while (!fdone[k] && n < budget) begin
            if (toggle) force_empty[k] = ~force_empty[k];
            tick(1);
            n++;
        end
        force_empty[k] = 1'b0;
        chk(tag, 64'(fdone[k]), 64'd1);
    endtask

    task automatic chk_frame(input int k, input int cap0, input int m0, input int size, input string tag);
        int nw;
        int bad;
        int np;
        logic [35:0] e;
        nw  = (size + LN - 1) / LN;
        bad = 0;
        for (int w = 0; w < nw; w++) begin
            np = (size - w*LN < LN) ? size - w*LN : LN;
            e  = exp_wk(k, m0 + w*LN, np);
            if ({cap_keep[k][cap0 + w], cap_data[k][cap0 + w]} !== e ||
                cap_last[k][cap0 + w] !== (w == nw - 1)) bad++;
        end
        chk({tag, "_nwords"}, 64'(ncap[k] - cap0), 64'(nw));
        chk({tag, "_words"}, 64'(bad), 64'd0);
    endtask

    initial begin
        int n;
        int bad;
        int c0;
        logic [31:0] d;
        logic [3:0]  kk;
        logic        l;

        rst = 1'b1;
        for (int k = 0; k < NB; k++) begin
            tready[k]      = 1'b0;
            force_empty[k] = 1'b0;
        end
        for (int i = 0; i < SZ0; i++) mem[0][i] = pix_pat(i);
        wp[0] = SZ0;
        tick(3);

        chk("rst_rd_en", 64'(rd_en[0]), 64'd0);
        chk("rst_tvalid", 64'(tvalid[0]), 64'd0);
        chk("rst_tdata", 64'(tdata[0]), 64'd0);
        chk("rst_tkeep", 64'(tkeep[0]), 64'd0);
        chk("rst_last_done", 64'({tlast[0], fdone[0]}), 64'd0);
        chk("rst_fcnt", 64'(fcnt[0]), 64'd0);

        // Full frame, tready always high
        tready[0] = 1'b1;
        rst = 1'b0;
        #1;
        chk("first_rd_en", 64'(rd_en[0]), 64'd1);
        n = 0;
        while (!tvalid[0] && n < 200) begin
            tick(1);
            n++;
        end
        chk("first_latency", 64'(n), 64'(LN + 1));
        chk("first_word", 64'(tdata[0]), 64'(FIRST_W));
        chk("first_keep", 64'(tkeep[0]), 64'hF);
        wait_fd(0, 20000, 1'b0, "frame1_done");
        chk("frame1_fcnt", 64'(fcnt[0]), 64'd1);
        tick(1);
        chk("frame1_ndone", 64'(nfd[0]), 64'd1);
        chk_frame(0, 0, 0, SZ0, "frame1");
        chk("frame1_last_word", 64'({cap_keep[0][NW0-1], cap_data[0][NW0-1]}), 64'(LAST_WK));

        // Same frame with the FIFO empty flag toggling every cycle
        force_empty[0] = 1'b1;
        for (int i = 0; i < SZ0; i++) mem[0][SZ0 + i] = pix_pat(i);
        c0 = ncap[0];
        wp[0] = 2 * SZ0;
        wait_fd(0, 40000, 1'b1, "frame2_done");
        chk("frame2_fcnt", 64'(fcnt[0]), 64'd2);
        chk_frame(0, c0, SZ0, SZ0, "frame2");
        chk("rd_while_empty", 64'(rd_viol[0]), 64'd0);

        // 10-pixel frame with a partial last word
        for (int i = 0; i < SZ1; i++) mem[1][i] = 8'(8'h11 + i);
        tready[1] = 1'b1;
        wp[1] = SZ1;
        wait_fd(1, 500, 1'b0, "small1_done");
        chk_frame(1, 0, 0, SZ1, "small1");
`ifdef ZED_DRAIN_BITPACK_EN
        chk("small1_w0", 64'({cap_last[1][0], cap_keep[1][0], cap_data[1][0]}), 64'({1'b1, 4'h3, 32'h000003FF}));
`else
        chk("small1_w0", 64'({cap_last[1][0], cap_keep[1][0], cap_data[1][0]}), 64'({1'b0, 4'hF, 32'h14131211}));
        chk("small1_w1", 64'({cap_last[1][1], cap_keep[1][1], cap_data[1][1]}), 64'({1'b0, 4'hF, 32'h18171615}));
        chk("small1_w2", 64'({cap_last[1][2], cap_keep[1][2], cap_data[1][2]}), 64'({1'b1, 4'h3, 32'h00001A19}));
`endif
        chk("small1_fcnt", 64'(fcnt[1]), 64'd1);

        // Backpressure: hold tready low for 20 cycles in SEND
        tready[1] = 1'b0;
        for (int i = 0; i < SZ1; i++) mem[1][SZ1 + i] = 8'(8'h21 + i);
        wp[1] = 2 * SZ1;
        n = 0;
        while (!tvalid[1] && n < 200) begin
            tick(1);
            n++;
        end
        chk("stall_valid", 64'(tvalid[1]), 64'd1);
        d   = tdata[1];
        kk  = tkeep[1];
        l   = tlast[1];
        bad = 0;
        repeat (20) begin
            tick(1);
            if (tdata[1] !== d || tkeep[1] !== kk || tlast[1] !== l || tvalid[1] !== 1'b1 || rd_en[1] !== 1'b0) bad++;
        end
        chk("stall_stable", 64'(bad), 64'd0);
`ifdef ZED_DRAIN_BITPACK_EN
        chk("stall_word", 64'({l, kk, d}), 64'({1'b1, 4'h3, 32'h000003FF}));
`else
        chk("stall_word", 64'({l, kk, d}), 64'({1'b0, 4'hF, 32'h24232221}));
`endif
        c0 = ncap[1];
        tready[1] = 1'b1;
        wait_fd(1, 500, 1'b0, "stall_done");
        chk_frame(1, c0, SZ1, SZ1, "stall");
        chk("stall_fcnt", 64'(fcnt[1]), 64'd2);

        // Reset with two lanes filled, then a fresh frame
        mem[1][20] = 8'h31;
        mem[1][21] = 8'h32;
        wp[1] = 22;
        tick(8);
        rst = 1'b1;
        tick(1);
        chk("mid_rst_out", 64'({rd_en[1], tvalid[1], tlast[1], fdone[1], tkeep[1], tdata[1]}), 64'd0);
        chk("mid_rst_fcnt", 64'(fcnt[1]), 64'd0);
        rst = 1'b0;
        for (int i = 0; i < SZ1; i++) mem[1][22 + i] = 8'(8'h41 + i);
        c0 = ncap[1];
        wp[1] = 32;
        wait_fd(1, 500, 1'b0, "post_rst_done");
        chk_frame(1, c0, 22, SZ1, "post_rst");
`ifndef ZED_DRAIN_BITPACK_EN
        chk("post_rst_w0", 64'(cap_data[1][c0]), 64'h44434241);
`endif
        chk("post_rst_fcnt", 64'(fcnt[1]), 64'd1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
